hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline interlock and issue scheduler for the 5-stage integer datapath.
- Tracks destination registers in flight in EX and MEM through a shadow scoreboard.
- Generates ALU-operand forwarding selects, load-use stalls, multi-cycle-op hold, and taken-branch flush.
- Sits beside the ID/EX pipeline register and drives the src1/src2 operand muxes and the IF/ID enables.

Parameters:
- DST_W, 5, register-index width.
- MULTI_CYC, 4, EX occupancy in cycles of a multi-cycle rmath op; legal range 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl_type  in  2  00 sw, 01 lw, 10 rmath, 11 imath.
- id_src1  in  DST_W  first source register.
- id_src2  in  DST_W  second source register.
- id_dst  in  DST_W  destination register.
- id_multi  in  1  rmath op is multi-cycle.
- ex_branch_taken  in  1  branch in EX resolved taken.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID contents.
- bubble_ex  out  1  load NOP into ID/EX this edge.
- flush_id  out  1  invalidate IF/ID this edge.
- fwd_src1  out  2  00 regfile, 01 EX result, 10 MEM result.
- fwd_src2  out  2  same encoding as fwd_src1.
- busy  out  1  FSM in MULTI.

Behaviour:
- Register use by type:
  - sw: reads src1 and src2, no write.
  - lw: reads src1, writes dst.
  - rmath: reads src1 and src2, writes dst.
  - imath: reads src1, writes dst.
- Register 0 never matches and is never forwarded.
- Scoreboard registers:
  - EX slot: ex_v, ex_dst, ex_ld.
  - MEM slot: mem_v, mem_dst.
- Scoreboard update on each clk edge:
  - MEM slot always takes the EX slot.
  - If the ID instruction advances: EX slot takes {id_valid and writes, id_dst, type==lw}.
  - If bubble_ex is asserted: EX slot is cleared.
  - In MULTI, both slots hold.
- Forwarding (combinational, per source):
  - Use 01 if the EX slot matches and ex_ld=0.
  - Else use 10 if the MEM slot matches.
  - Else use 00.
  - EX has priority over MEM.
  - A source the instruction type does not read forces 00.
- FSM states: RUN, LDSTALL, MULTI. Reset state is RUN, counter cnt=0.
- RUN:
  - Load-use: a used source matches the EX slot with ex_ld=1. Assert stall_if, stall_id, bubble_ex this cycle and go to LDSTALL. fwd for that source is 00 this cycle.
  - Multi-cycle issue: ID instruction is valid rmath with id_multi=1 and no load-use. It advances; go to MULTI with cnt=MULTI_CYC-1.
  - Otherwise all stall outputs are 0.
- LDSTALL:
  - Lasts exactly one cycle with no stall outputs; go to RUN.
  - The loaded value is now in MEM and is forwarded as 10.
- MULTI:
  - stall_if=stall_id=1, bubble_ex=0, busy=1; cnt decrements each cycle.
  - When cnt==1, go to RUN. EX is therefore occupied exactly MULTI_CYC cycles.
  - Forwarding outputs are forced to 00 while in MULTI.
- ex_branch_taken:
  - Sampled only in RUN.
  - Asserts flush_id and bubble_ex and suppresses load-use and multi-cycle issue that cycle; state stays RUN.
  - Ignored in LDSTALL and MULTI.
- Simultaneous load-use and a multi-cycle instruction in ID: load-use wins. The multi-cycle op issues after LDSTALL.
- id_valid=0: no hazards, no issue, fwd=00; the EX slot loads invalid.
- Reset (async, any state, mid-stall or mid-MULTI):
  - state RUN, cnt 0, all scoreboard valids 0.
  - All outputs 0: stall_if, stall_id, bubble_ex, flush_id, busy, fwd_src1=fwd_src2=00.
- No latency on outputs: all outputs are combinational from state, scoreboard, and current ID inputs.

Test Plan:
- Back-to-back dependency: rmath r3 (dst) then rmath src1=r3, src2=r4 -> second cycle fwd_src1=01, fwd_src2=00, no stall.
- Distance 2: imath dst=r5, unrelated op, then sw src2=r5 -> fwd_src2=10.
- Both slots match: EX dst=r6 and MEM dst=r6 -> fwd=01.
- Load-use: lw dst=r7 then rmath src2=r7 -> one cycle with stall_if=stall_id=bubble_ex=1; next cycle no stall, fwd_src2=10.
- Multi-cycle op: rmath id_multi=1 with MULTI_CYC=4 -> busy and stalls high for exactly 3 cycles after issue, then RUN.
- Register 0: dst=r0 followed by src1=r0 -> fwd=00.
- Taken branch with a load-use pending in ID -> flush_id=bubble_ex=1, stall_if=0, state stays RUN.
- Reset: assert rst during MULTI with cnt=2 -> all outputs 0 immediately (async); first instruction after release sees no hazard.

Source files
------------

// File: rtl/hazard_sched.sv
// Interlock and issue scheduler for the 5-stage integer pipe: tracks EX/MEM
// destinations, selects operand forwarding, and raises load-use, multi-cycle and branch-flush controls.
module hazard_sched #(
  parameter int DST_W     = 5,
  parameter int MULTI_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_ctrl_type,
  input  logic [DST_W-1:0] id_src1,
  input  logic [DST_W-1:0] id_src2,
  input  logic [DST_W-1:0] id_dst,
  input  logic             id_multi,
  input  logic             ex_branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_src1,
  output logic [1:0]       fwd_src2,
  output logic             busy
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MULTI   = 2'd2
  } state_t;

  localparam logic [1:0] T_SW    = 2'b00;
  localparam logic [1:0] T_LW    = 2'b01;
  localparam logic [1:0] T_RMATH = 2'b10;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic             r_ex_v, r_ex_ld, r_mem_v;
  logic [DST_W-1:0] r_ex_dst, r_mem_dst;

  logic w_use1, w_use2, w_writes, w_is_lw, w_multi_req;
  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_load_use;
  logic w_adv, w_stall_if, w_stall_id, w_bubble, w_flush, w_busy;
  logic [1:0] w_fwd1, w_fwd2, w_sel1, w_sel2;

  // Source usage by type: every type reads src1; only sw and rmath read src2.
  assign w_use1      = id_valid;
  assign w_use2      = id_valid && (id_ctrl_type == T_SW || id_ctrl_type == T_RMATH);
  assign w_writes    = (id_ctrl_type != T_SW);
  assign w_is_lw     = (id_ctrl_type == T_LW);
  assign w_multi_req = id_valid && (id_ctrl_type == T_RMATH) && id_multi;

  // r0 is hardwired zero, so it never creates a dependency.
  assign w_ex_m1  = r_ex_v  && (id_src1 != '0) && (id_src1 == r_ex_dst);
  assign w_ex_m2  = r_ex_v  && (id_src2 != '0) && (id_src2 == r_ex_dst);
  assign w_mem_m1 = r_mem_v && (id_src1 != '0) && (id_src1 == r_mem_dst);
  assign w_mem_m2 = r_mem_v && (id_src2 != '0) && (id_src2 == r_mem_dst);

  assign w_load_use = r_ex_ld && ((w_use1 && w_ex_m1) || (w_use2 && w_ex_m2));

  // A load still in EX has no result yet, so an EX hit on a load selects the regfile.
  function automatic logic [1:0] fwd_sel(input logic use_s, input logic ex_m,
                                         input logic ex_ld, input logic mem_m);
    if (!use_s) return 2'b00;
    if (ex_m)   return ex_ld ? 2'b00 : 2'b01;
    if (mem_m)  return 2'b10;
    return 2'b00;
  endfunction

  assign w_sel1 = fwd_sel(w_use1, w_ex_m1, r_ex_ld, w_mem_m1);
  assign w_sel2 = fwd_sel(w_use2, w_ex_m2, r_ex_ld, w_mem_m2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_busy      = 1'b0;
    w_fwd1      = w_sel1;
    w_fwd2      = w_sel2;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_load_use) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_bubble    = 1'b1;
          w_state_nxt = LDSTALL;
        end else begin
          w_adv = 1'b1;
          if (w_multi_req) begin
            w_state_nxt = MULTI;
            w_cnt_nxt   = 4'(MULTI_CYC - 1);
          end
        end
      end
      LDSTALL: begin
        // EX holds the bubble here, so the held instruction always issues now.
        w_adv       = 1'b1;
        w_state_nxt = RUN;
        if (w_multi_req) begin
          w_state_nxt = MULTI;
          w_cnt_nxt   = 4'(MULTI_CYC - 1);
        end
      end
      MULTI: begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_busy     = 1'b1;
        w_fwd1     = 2'b00;
        w_fwd2     = 2'b00;
        w_cnt_nxt  = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Shadow scoreboard; frozen while the multi-cycle op occupies EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_v    <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_dst  <= '0;
      r_mem_v   <= 1'b0;
      r_mem_dst <= '0;
    end else if (r_state != MULTI) begin
      r_mem_v   <= r_ex_v;
      r_mem_dst <= r_ex_dst;
      if (w_bubble) begin
        r_ex_v  <= 1'b0;
        r_ex_ld <= 1'b0;
      end else if (w_adv) begin
        r_ex_v   <= id_valid && w_writes;
        r_ex_dst <= id_dst;
        r_ex_ld  <= id_valid && w_is_lw;
      end
    end
  end

  // Reset forces every control low immediately, independent of the ID inputs.
  assign stall_if  = w_stall_if & ~rst;
  assign stall_id  = w_stall_id & ~rst;
  assign bubble_ex = w_bubble   & ~rst;
  assign flush_id  = w_flush    & ~rst;
  assign busy      = w_busy     & ~rst;
  assign fwd_src1  = rst ? 2'b00 : w_fwd1;
  assign fwd_src2  = rst ? 2'b00 : w_fwd2;

endmodule

// File: tb/tb_hazard_sched.sv
// Scenario bench for hazard_sched: per-cycle ID stimulus with expected control
// vectors queued at drive time and compared on the falling edge.
module tb_hazard_sched;

  localparam logic [1:0] SW = 2'b00, LW = 2'b01, RM = 2'b10, IM = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [1:0] id_ctrl_type = 2'b00;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic       id_multi = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       stall_if, stall_id, bubble_ex, flush_id, busy;
  logic [1:0] fwd_src1, fwd_src2;

  hazard_sched #(.DST_W(5), .MULTI_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ctrl_type(id_ctrl_type),
    .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
    .id_multi(id_multi), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .fwd_src1(fwd_src1), .fwd_src2(fwd_src2), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected vector layout: {stall_if, stall_id, bubble_ex, flush_id, busy, fwd1, fwd2}
  typedef struct packed {
    logic       v;
    logic [1:0] t;
    logic [4:0] s1, s2, d;
    logic       m, br;
    logic [8:0] e;
  } row_t;

  row_t       stim_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got, e;
  row_t       r;
  int         n_chk = 0;
  int         n_err = 0;

  localparam logic [8:0] Z     = 9'b000000000;
  localparam logic [8:0] E_LU  = 9'b111000000;
  localparam logic [8:0] E_MUL = 9'b110010000;
  localparam logic [8:0] E_BR  = 9'b001100000;

  function automatic logic [8:0] fw(input logic [1:0] f1, input logic [1:0] f2);
    return {5'b00000, f1, f2};
  endfunction

  function automatic row_t mk(input logic v, input logic [1:0] t, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [4:0] d, input logic m,
                              input logic br, input logic [8:0] ex);
    row_t x;
    x.v = v; x.t = t; x.s1 = s1; x.s2 = s2; x.d = d; x.m = m; x.br = br; x.e = ex;
    return x;
  endfunction

  function automatic logic [8:0] outs();
    return {stall_if, stall_id, bubble_ex, flush_id, busy, fwd_src1, fwd_src2};
  endfunction

  task automatic drive(input row_t x);
    id_valid = x.v; id_ctrl_type = x.t; id_src1 = x.s1; id_src2 = x.s2;
    id_dst = x.d; id_multi = x.m; ex_branch_taken = x.br;
    exp_q.push_back(x.e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, SW, 0, 0, 0, 0, 0, Z));
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int k = 0;
    rst = 1'b1;
    drive(mk(1, RM, 1, 2, 3, 1, 1, Z));
    @(negedge clk);
    got = outs(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL reset_held got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q.push_back(mk(0, SW, 0, 0, 0, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 3, 3, 3, 0, 0, Z));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reset_after step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, RM, 1, 2, 3, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 3, 4, 8, 0, 0, fw(2'b01, 2'b00)));
    stim_q.push_back(mk(1, SW, 8, 3, 0, 0, 0, fw(2'b01, 2'b10)));
    stim_q.push_back(mk(1, IM, 8, 8, 9, 0, 0, fw(2'b10, 2'b00)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL back_to_back step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_distance2();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, IM, 1, 0, 5, 0, 0, Z));
    stim_q.push_back(mk(1, IM, 2, 0, 9, 0, 0, Z));
    stim_q.push_back(mk(1, SW, 1, 5, 0, 0, 0, fw(2'b00, 2'b10)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL distance2 step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_both_slots();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, IM, 1, 0, 6, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 2, 3, 6, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 6, 6, 4, 0, 0, fw(2'b01, 2'b01)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL both_slots step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, LW, 1, 0, 7, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 2, 7, 10, 0, 0, E_LU));
    stim_q.push_back(mk(1, RM, 2, 7, 10, 0, 0, fw(2'b00, 2'b10)));
    stim_q.push_back(mk(1, IM, 10, 0, 11, 0, 0, fw(2'b01, 2'b00)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL load_use step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_multi();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, RM, 1, 2, 11, 1, 0, Z));
    stim_q.push_back(mk(1, IM, 11, 0, 12, 0, 0, E_MUL));
    stim_q.push_back(mk(1, IM, 11, 0, 12, 0, 1, E_MUL));
    stim_q.push_back(mk(1, IM, 11, 0, 12, 0, 0, E_MUL));
    stim_q.push_back(mk(1, IM, 11, 0, 12, 0, 0, fw(2'b01, 2'b00)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL multi step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reg0();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, IM, 1, 0, 0, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 0, 0, 0, 0, 0, Z));
    stim_q.push_back(mk(1, LW, 1, 0, 0, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 0, 0, 2, 0, 0, Z));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reg0 step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, LW, 1, 0, 7, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 7, 2, 8, 0, 1, E_BR));
    stim_q.push_back(mk(1, RM, 7, 2, 8, 0, 0, fw(2'b10, 2'b00)));
    stim_q.push_back(mk(1, RM, 3, 4, 9, 1, 1, E_BR));
    stim_q.push_back(mk(0, SW, 0, 0, 0, 0, 0, Z));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL branch step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_lu_vs_multi();
    int k = 0;
    do_reset();
    stim_q.push_back(mk(1, LW, 1, 0, 7, 0, 0, Z));
    stim_q.push_back(mk(1, RM, 7, 2, 8, 1, 0, E_LU));
    stim_q.push_back(mk(1, RM, 7, 2, 8, 1, 0, fw(2'b10, 2'b00)));
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); drive(r); @(negedge clk);
      got = outs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL lu_vs_multi step%0d got=%b exp=%b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_multi();
    do_reset();
    drive(mk(1, RM, 1, 2, 11, 1, 0, Z));
    @(negedge clk);
    got = outs(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_multi issue got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    drive(mk(1, IM, 11, 0, 12, 0, 0, E_MUL));
    @(negedge clk);
    got = outs(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_multi busy got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    // counter is now 2; reset lands between edges
    exp_q.push_back(Z);
    rst = 1'b1;
    #2;
    got = outs(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_multi async got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(mk(1, IM, 11, 0, 12, 0, 0, Z));
    @(negedge clk);
    got = outs(); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_multi after got=%b exp=%b", got, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_both_slots();
    test_load_use();
    test_multi();
    test_reg0();
    test_branch();
    test_lu_vs_multi();
    test_reset_multi();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
